// File: rtl/dcp_pkg.sv
// Shared memory-request types for the DCP request path and the descriptor splitter.
package dcp_pkg;
  typedef logic [39:0] paddr_t;
  typedef logic [7:0]  mshrid_t;
  typedef logic [2:0]  size_t;
  typedef logic [15:0] homeid_t;
  typedef logic [7:0]  write_mask_t;
  typedef logic [63:0] data_t;

  typedef enum logic [1:0] {
    REQ_READ   = 2'd0,
    REQ_WRITE  = 2'd1,
    REQ_ATOMIC = 2'd2
  } req_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } splitter_state_t;

  // A 16-byte request is only legal on a 16-byte boundary with two words left.
  function automatic size_t chunk_size(input logic [3:0] addr_lo, input logic two_left);
    return (two_left && addr_lo == 4'h0) ? size_t'(2) : size_t'(1);
  endfunction
endpackage

// File: rtl/mem_req_splitter_mshr_pool.sv
// Request-ID pool: one free bit per ID, lowest-free priority pick, alloc/free updates.
module mshr_pool
  import dcp_pkg::*;
#(
  parameter int unsigned NUM_MSHR = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    alloc_en,
  input  mshrid_t alloc_id,
  input  logic    free_en,
  input  mshrid_t free_id,
  output logic    any_free,
  output logic    all_free,
  output mshrid_t lowest_free
);
  logic [NUM_MSHR-1:0] free_vec;

  // Out-of-range or already-free IDs never match a busy slot, so they fall through untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_vec <= '1;
    end else begin
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
        if (alloc_en && alloc_id == mshrid_t'(i)) begin
          free_vec[i] <= 1'b0;
        end else if (free_en && free_id == mshrid_t'(i)) begin
          free_vec[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    lowest_free = '0;
    for (int unsigned i = NUM_MSHR; i > 0; i--) begin
      if (free_vec[i-1]) lowest_free = mshrid_t'(i - 1);
    end
  end

  assign any_free = |free_vec;
  assign all_free = &free_vec;
endmodule

// File: rtl/mem_req_splitter.sv
// Splits a word-count DMA descriptor into 8/16-byte read requests, one request ID each,
// and signals completion once every ID handed out has been returned.
module mem_req_splitter
  import dcp_pkg::*;
#(
  parameter int unsigned NUM_MSHR = 8,
  parameter int unsigned LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  paddr_t           desc_addr,
  input  logic [LEN_W-1:0] desc_words,
  input  homeid_t          desc_homeid,
  output logic             req_valid,
  input  logic             req_ready,
  output req_type_t        req_type,
  output mshrid_t          req_mshrid,
  output paddr_t           req_address,
  output size_t            req_size,
  output homeid_t          req_homeid,
  output write_mask_t      req_write_mask,
  output data_t            req_data_0,
  output data_t            req_data_1,
  input  logic             rsp_valid,
  input  mshrid_t          rsp_mshrid,
  output logic             done,
  output logic             busy
);
  splitter_state_t  state_q;
  paddr_t           addr_q;
  logic [LEN_W-1:0] rem_q;
  paddr_t           desc_base;
  logic             hs;
  logic             any_free;
  logic             all_free;
  mshrid_t          lowest_free;

  assign hs             = req_valid && req_ready;
  assign desc_base      = desc_addr & ~paddr_t'(7);
  assign desc_ready     = (state_q == ST_IDLE);
  assign req_type       = REQ_READ;
  assign req_write_mask = '0;
  assign req_data_0     = '0;
  assign req_data_1     = '0;

  mshr_pool #(
    .NUM_MSHR(NUM_MSHR)
  ) u_pool (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (hs),
    .alloc_id   (req_mshrid),
    .free_en    (rsp_valid),
    .free_id    (rsp_mshrid),
    .any_free   (any_free),
    .all_free   (all_free),
    .lowest_free(lowest_free)
  );

  // addr_q/rem_q track the next chunk to issue; the first chunk is launched straight
  // from the descriptor inputs so req_valid appears the cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      req_valid   <= 1'b0;
      req_mshrid  <= '0;
      req_address <= '0;
      req_size    <= '0;
      req_homeid  <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (desc_valid) begin
            if (desc_words == '0) begin
              done <= 1'b1;
            end else begin
              state_q    <= ST_ISSUE;
              busy       <= 1'b1;
              addr_q     <= desc_base;
              rem_q      <= desc_words;
              req_homeid <= desc_homeid;
              if (any_free) begin
                req_valid   <= 1'b1;
                req_mshrid  <= lowest_free;
                req_address <= desc_base;
                req_size    <= chunk_size(desc_base[3:0], desc_words >= LEN_W'(2));
              end
            end
          end
        end
        ST_ISSUE: begin
          if (req_valid) begin
            if (req_ready) begin
              req_valid <= 1'b0;
              addr_q    <= addr_q + (paddr_t'(req_size) << 3);
              rem_q     <= rem_q - LEN_W'(req_size);
              if (rem_q == LEN_W'(req_size)) state_q <= ST_DRAIN;
            end
          end else if (rem_q != '0 && any_free) begin
            req_valid   <= 1'b1;
            req_mshrid  <= lowest_free;
            req_address <= addr_q;
            req_size    <= chunk_size(addr_q[3:0], rem_q >= LEN_W'(2));
          end
        end
        ST_DRAIN: begin
          if (all_free) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_splitter.sv
// Bench for mem_req_splitter: vector table, directed corner sequences and random descriptors
// checked against a chunk-list / ID-set reference model.
module tb_mem_req_splitter;
  import dcp_pkg::*;

  localparam int unsigned NM = 8;
  localparam int unsigned LW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, desc_valid, desc_ready, req_valid, req_ready, rsp_valid, done, busy;
  paddr_t        desc_addr, req_address;
  logic [LW-1:0] desc_words;
  homeid_t       desc_homeid, req_homeid;
  req_type_t     req_type;
  mshrid_t       req_mshrid, rsp_mshrid;
  size_t         req_size;
  write_mask_t   req_write_mask;
  data_t         req_data_0, req_data_1;

  mem_req_splitter #(.NUM_MSHR(NM), .LEN_W(LW)) u_dut (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_words(desc_words), .desc_homeid(desc_homeid),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_mshrid(req_mshrid), .req_address(req_address), .req_size(req_size),
    .req_homeid(req_homeid), .req_write_mask(req_write_mask), .req_data_0(req_data_0),
    .req_data_1(req_data_1), .rsp_valid(rsp_valid), .rsp_mshrid(rsp_mshrid),
    .done(done), .busy(busy)
  );

  logic          b_rst_n, b_desc_valid, b_desc_ready, b_req_valid, b_req_ready, b_rsp_valid, b_done, b_busy;
  paddr_t        b_desc_addr, b_req_address;
  logic [LW-1:0] b_desc_words;
  homeid_t       b_desc_homeid, b_req_homeid;
  req_type_t     b_req_type;
  mshrid_t       b_req_mshrid, b_rsp_mshrid;
  size_t         b_req_size;
  write_mask_t   b_req_write_mask;
  data_t         b_req_data_0, b_req_data_1;

  mem_req_splitter #(.NUM_MSHR(2), .LEN_W(LW)) u_dut2 (
    .clk(clk), .rst_n(b_rst_n), .desc_valid(b_desc_valid), .desc_ready(b_desc_ready),
    .desc_addr(b_desc_addr), .desc_words(b_desc_words), .desc_homeid(b_desc_homeid),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_type(b_req_type),
    .req_mshrid(b_req_mshrid), .req_address(b_req_address), .req_size(b_req_size),
    .req_homeid(b_req_homeid), .req_write_mask(b_req_write_mask), .req_data_0(b_req_data_0),
    .req_data_1(b_req_data_1), .rsp_valid(b_rsp_valid), .rsp_mshrid(b_rsp_mshrid),
    .done(b_done), .busy(b_busy)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: expected chunk list plus the set of IDs currently held by the bench.
  typedef struct { paddr_t a; int unsigned s; } chunk_t;
  typedef struct { mshrid_t id; int unsigned due; } pend_t;
  chunk_t exp_q[$];
  pend_t  pend_q[$];
  bit     m_busy[NM];

  function automatic int lowest_free_m();
    for (int i = 0; i < int'(NM); i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic bit any_busy_m();
    for (int i = 0; i < int'(NM); i++) if (m_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NM); i++) m_busy[i] = 1'b0;
    pend_q.delete();
    exp_q.delete();
  endtask

  task automatic build_expect(input paddr_t a, input int unsigned w);
    longint unsigned addr;
    int unsigned     rem, s;
    addr = longint'(a) - (longint'(a) % 8);
    rem  = w;
    exp_q.delete();
    while (rem > 0) begin
      s = (rem >= 2 && addr % 16 == 0) ? 2 : 1;
      exp_q.push_back('{a: paddr_t'(addr), s: s});
      addr = (addr + 8 * s) % (64'd1 << 40);
      rem -= s;
    end
  endtask

  task automatic run_desc(input paddr_t a, input int unsigned w, input int unsigned pct,
                          input int unsigned hold, input int unsigned lat,
                          output int unsigned nreq, output int unsigned first_sz,
                          output paddr_t last_a);
    homeid_t     hid;
    logic        prev_valid, prev_ready, prev_rsp, seen_done;
    mshrid_t     prev_rsp_id, cur_id;
    paddr_t      prev_addr;
    int unsigned prev_size, done_cyc;
    int          lf;
    hid = homeid_t'($urandom);
    build_expect(a, w);
    nreq = 0; first_sz = 0; last_a = '0;
    @(negedge clk);
    chk("desc_ready_idle", desc_ready, 1'b1);
    desc_valid = 1'b1; desc_addr = a; desc_words = LW'(w); desc_homeid = hid;
    @(negedge clk);
    desc_valid = 1'b0;
    chk("first_valid_latency", req_valid, w > 0);
    prev_valid = 1'b0; prev_ready = 1'b0; prev_rsp = 1'b0; prev_rsp_id = '0;
    cur_id = '0; prev_addr = '0; prev_size = 0; seen_done = 1'b0; done_cyc = 0;
    for (int unsigned cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      if (cyc != 0) @(negedge clk);
      // IDs freed or taken at the edge just passed are not visible to a same-edge launch.
      lf = lowest_free_m();
      if (!prev_valid && (lf < 0 || exp_q.size() == 0))
        chk("no_req_without_id_or_work", req_valid, 1'b0);
      else if (req_valid && !prev_valid)
        cur_id = mshrid_t'(lf);
      if (prev_valid && !prev_ready) chk("valid_held", req_valid, 1'b1);
      if (req_valid && exp_q.size() != 0) begin
        chk("req_address", req_address, exp_q[0].a);
        chk("req_size", req_size, exp_q[0].s);
        chk("req_mshrid", req_mshrid, cur_id);
        chk("req_homeid", req_homeid, hid);
        chk("req_type", req_type, REQ_READ);
        chk("req_zero_fields", req_data_0 | req_data_1 | data_t'(req_write_mask), '0);
        chk("busy_issue", busy, 1'b1);
      end
      if (prev_rsp && int'(prev_rsp_id) < int'(NM)) m_busy[int'(prev_rsp_id)] = 1'b0;
      if (prev_valid && prev_ready) begin
        m_busy[int'(cur_id)] = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        nreq++;
        if (nreq == 1) first_sz = prev_size;
        last_a = prev_addr;
        pend_q.push_back('{id: cur_id, due: cyc + lat + $urandom_range(3)});
      end
      if (exp_q.size() != 0 || any_busy_m()) chk("done_early", done, 1'b0);
      if (done) begin seen_done = 1'b1; done_cyc = cyc; end
      req_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pct);
      rsp_valid = 1'b0;
      for (int i = 0; i < pend_q.size(); i++) begin
        if (pend_q[i].due <= cyc) begin
          rsp_valid = 1'b1; rsp_mshrid = pend_q[i].id; pend_q.delete(i); break;
        end
      end
      if (!rsp_valid && $urandom_range(7) == 0) begin
        rsp_valid = 1'b1;
        lf = lowest_free_m();
        rsp_mshrid = (lf >= 0 && $urandom_range(1) == 1) ? mshrid_t'(lf)
                                                         : mshrid_t'($urandom_range(255, NM));
      end
      prev_valid = req_valid; prev_ready = req_ready; prev_rsp = rsp_valid;
      prev_rsp_id = rsp_mshrid; prev_addr = req_address; prev_size = req_size;
    end
    rsp_valid = 1'b0; req_ready = 1'b0;
    if (!seen_done) begin
      chk("done_timeout", seen_done, 1'b1);
    end else begin
      if (w == 0) chk("zero_len_done_latency", done_cyc, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("busy_after_done", busy, 1'b0);
      chk("chunks_left", exp_q.size(), 0);
    end
  endtask

  typedef struct {
    paddr_t      addr;
    int unsigned words, pct, hold, lat, exp_n, exp_first;
    paddr_t      exp_last;
  } vec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    int unsigned nreq, fsz, nh;
    paddr_t      la;
    mshrid_t     b_id0, b_id1;

    vecs[0] = '{40'h1000, 5, 100, 0, 20, 3, 2, 40'h1020};
    vecs[1] = '{40'h1008, 3, 100, 0, 20, 2, 1, 40'h1010};
    vecs[2] = '{40'h2000, 0, 100, 0, 1, 0, 0, 40'h0};
    vecs[3] = '{40'h1005, 1, 100, 0, 1, 1, 1, 40'h1000};
    vecs[4] = '{40'hFF_FFFF_FFF0, 4, 100, 0, 2, 2, 2, 40'h0};
    vecs[5] = '{40'h3000, 6, 100, 10, 3, 3, 2, 40'h3020};
    vecs[6] = '{40'h5000, 20, 100, 0, 30, 10, 2, 40'h5090};

    rst_n = 1'b0; desc_valid = 1'b0; desc_addr = '0; desc_words = '0; desc_homeid = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_mshrid = '0;
    b_rst_n = 1'b0; b_desc_valid = 1'b0; b_desc_addr = '0; b_desc_words = '0; b_desc_homeid = '0;
    b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_mshrid = '0;
    model_reset();
    #1;
    chk("reset_req_valid", req_valid, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_desc_ready", desc_ready, 1'b1);
    chk("reset_payload", {req_address, req_mshrid, req_size}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; b_rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_desc(vecs[i].addr, vecs[i].words, vecs[i].pct, vecs[i].hold, vecs[i].lat, nreq, fsz, la);
      chk($sformatf("vec%0d_nreq", i), nreq, vecs[i].exp_n);
      chk($sformatf("vec%0d_first_size", i), fsz, vecs[i].exp_first);
      chk($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last);
    end

    // Two-ID instance: pool exhaustion, then reuse of the returned ID.
    @(negedge clk);
    b_desc_valid = 1'b1; b_desc_addr = '0; b_desc_words = LW'(8); b_req_ready = 1'b1;
    @(negedge clk);
    b_desc_valid = 1'b0;
    nh = 0; b_id0 = 8'hFF; b_id1 = 8'hFF;
    repeat (20) begin
      if (b_req_valid && b_req_ready) begin
        if (nh == 0) b_id0 = b_req_mshrid;
        if (nh == 1) b_id1 = b_req_mshrid;
        nh++;
      end
      @(negedge clk);
    end
    chk("b_two_requests", nh, 2);
    chk("b_first_id", b_id0, 0);
    chk("b_second_id", b_id1, 1);
    chk("b_stalled_valid", b_req_valid, 1'b0);
    b_rsp_valid = 1'b1; b_rsp_mshrid = 8'd0;
    @(negedge clk);
    b_rsp_valid = 1'b0;
    for (int i = 0; i < 10 && !b_req_valid; i++) @(negedge clk);
    chk("b_third_valid", b_req_valid, 1'b1);
    chk("b_third_id", b_req_mshrid, 0);
    chk("b_third_addr", b_req_address, 40'h20);
    b_rst_n = 1'b0;

    // Reset in the middle of issuing.
    @(negedge clk);
    desc_valid = 1'b1; desc_addr = 40'h6000; desc_words = LW'(10);
    @(negedge clk);
    desc_valid = 1'b0; req_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", req_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_req_valid", req_valid, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_payload", {req_address, req_mshrid, req_size}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rsp_valid = 1'b1; rsp_mshrid = 8'd0;
    @(negedge clk);
    rsp_valid = 1'b0;
    run_desc(40'h7000, 5, 100, 0, 20, nreq, fsz, la);
    chk("post_reset_nreq", nreq, 3);

    for (int i = 0; i < 20; i++) begin
      run_desc(paddr_t'({$urandom, $urandom}), $urandom_range(24), $urandom_range(100, 30),
               $urandom_range(3), $urandom_range(10, 1), nreq, fsz, la);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_req_splitter.md
MEM_REQ_SPLITTER -- requirements
Module: mem_req_splitter

Interface
REQ-001 Parameter NUM_MSHR, default 8, number of request IDs in the local pool (2..2^width of mshrid_t).
REQ-002 Parameter LEN_W, default 16, width of the descriptor word count.
REQ-003 clk  input  1  single clock; all state samples on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 desc_valid / desc_ready  input / output  1 / 1  descriptor handshake.
REQ-006 desc_addr  input  paddr_t  byte base address, 8-byte aligned (low 3 bits ignored).
REQ-007 desc_words  input  LEN_W  transfer length in 8-byte words.
REQ-008 desc_homeid  input  homeid_t  home ID copied to every generated request.
REQ-009 req_valid / req_ready  output / input  1 / 1  memory-request handshake, master side.
REQ-010 req_type, req_mshrid, req_address, req_size, req_homeid, req_write_mask, req_data_0, req_data_1  output  dcp_pkg types  request payload; real size = req_size * 8 bytes.
REQ-011 rsp_valid  input 1; rsp_mshrid  input mshrid_t  response-complete notice releasing one ID.
REQ-012 done  output 1  one-cycle pulse when a descriptor is fully issued and all its IDs released.
REQ-013 busy  output 1  high from descriptor accept until done.

Function
REQ-014 FSM states IDLE, ISSUE, DRAIN; desc_ready=1 only in IDLE.
REQ-015 IDLE: on desc_valid&desc_ready latch addr, words, homeid; words==0 -> pulse done next cycle, stay IDLE; else -> ISSUE.
REQ-016 ISSUE: req_valid asserts when remaining>0 and at least one ID free; payload computed once at assertion and held stable until req_ready.
REQ-017 req_size = 2 if remaining>=2 and address[3:0]==0, else 1.
REQ-018 req_type = REQ_READ; req_write_mask = 0; req_data_0/1 = 0.
REQ-019 req_mshrid = lowest-numbered free ID at assertion; marked busy on handshake.
REQ-020 On handshake: address += req_size*8 (wraps modulo paddr_t width), remaining -= req_size; remaining==0 -> DRAIN.
REQ-021 Once asserted, req_valid stays high until req_ready (no retraction).
REQ-022 DRAIN: when all IDs free, pulse done for one cycle -> IDLE.
REQ-023 rsp_valid frees rsp_mshrid next cycle; a freed ID is allocatable the cycle after the free.
REQ-024 Free and allocate in same cycle: both take effect; a same-cycle freed ID is not chosen that cycle.
REQ-025 rsp_mshrid >= NUM_MSHR or already free: ignored, no state change.
REQ-026 All IDs busy: req_valid held low, no counter change.
REQ-027 Latency: first req_valid one cycle after descriptor accept.

Reset
REQ-028 rst_n low immediately: FSM IDLE, all IDs free, req_valid=0, done=0, busy=0, desc_ready=1 after release, payload registers zero.
REQ-029 Reset mid-transfer abandons outstanding requests; post-reset responses for old IDs are ignored per REQ-025.

Structure
REQ-030 REQ_READ, req_type_t, mshrid_t, paddr_t, size_t, homeid_t, write_mask_t, data_t live in dcp_pkg; no new types local.
REQ-031 One sub-module, mshr_pool: free bit vector, lowest-free priority encoder, alloc/free ports.

Verification
REQ-032 addr 0x1000, words 5, req_ready=1 -> sizes 2,2,1 at 0x1000,0x1010,0x1020, IDs 0,1,2; done after 3 responses.
REQ-033 addr 0x1008, words 3 -> sizes 1,2 at 0x1008,0x1010.
REQ-034 NUM_MSHR=2, words 8, no responses -> exactly 2 requests then req_valid low; free ID 0 -> third request uses ID 0.
REQ-035 req_ready held low 10 cycles -> req_valid and payload stable all 10 cycles.
REQ-036 words 0 -> no req_valid, done pulses one cycle after accept.
REQ-037 Assert rst_n low during ISSUE -> req_valid low same cycle, busy 0, new descriptor accepted after release.
